multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control unit for the multicycle RV32I core. It sequences the shared datapath one instruction at a time, driving the memory address select, IR/PC enables, ALU operand selects, ALU operation, register write, and the 2-bit `result_src` that steers the writeback result multiplexer. It supports a ready/request handshake with the unified instruction/data memory and enters a sticky trap on illegal opcodes or memory timeout.

## Interface
- `WAIT_LIMIT`, default 15: maximum consecutive memory stall cycles before a bus error. A value of 0 disables the timeout.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  7  instruction opcode field, taken from the registered IR
- `funct3`  in  3  instruction bits 14:12
- `funct7b5`  in  1  instruction bit 30
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access requested
- `mem_write`  out  1  the requested access is a store
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR and OldPC
- `pc_write`  out  1  load PC from the result bus
- `result_src`  out  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result
- `alu_src_a`  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b`  out  2  ALU B operand: 00 = rs2, 01 = immediate, 10 = constant 4
- `alu_control`  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `reg_write`  out  1  register file write enable
- `state_o`  out  4  current state encoding, for debug
- `bus_error`  out  1  sticky memory timeout flag
- `illegal_instr`  out  1  sticky illegal opcode flag

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, TRAP 11.
- Unlisted outputs in each state are 0. Internal ALUOp is 00 = add, 01 = sub, 10 = decode from funct fields.
- FETCH: `mem_req`=1, `adr_src`=0, A=00, B=10, ALUOp 00, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready`. Advances to DECODE on `mem_ready`.
- DECODE: A=01, B=01, ALUOp 00. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → TRAP, setting `illegal_instr`
- MEMADR: A=10, B=01, ALUOp 00. Goes to MEMREAD if `op[5]`=0, otherwise MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00. Advances to MEMWB on `mem_ready`.
- MEMWB: `result_src`=01, `reg_write`=1. Returns to FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00. Advances to FETCH on `mem_ready`.
- EXECUTER: A=10, B=00, ALUOp 10. Goes to ALUWB.
- EXECUTEI: A=10, B=01, ALUOp 10. Goes to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Returns to FETCH.
- JAL: A=01, B=10, ALUOp 00, `result_src`=00, `pc_write`=1. Goes to ALUWB.
- BEQ: A=10, B=00, ALUOp 01, `result_src`=00, `pc_write`=`zero`. Returns to FETCH.
- TRAP: all enables 0 and `mem_req`=0. TRAP is absorbing; only `rst` exits it.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by `funct3`:
    - 000 → sub if `funct7b5` and `op[5]` are both 1, otherwise add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other value → add
- Wait counter:
  - Increments on every cycle with `mem_req`=1 and `mem_ready`=0.
  - Clears on `mem_ready` and on every state change.
  - Width is `$clog2(WAIT_LIMIT+1)`; the counter never wraps.
  - When a stall cycle occurs with count = `WAIT_LIMIT`−1, the next state is TRAP and `bus_error` sets.

## Timing
- Outputs are Moore decodes of the state, except for the Mealy terms `ir_write`/`pc_write` in FETCH (gated by `mem_ready`) and `pc_write` in BEQ (gated by `zero`).
- Reset values (state FETCH): `mem_req`=1, `alu_src_b`=10, `result_src`=10, `state_o`=0, `alu_control`=000. All other outputs are 0, including `bus_error` and `illegal_instr`.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3. Each stall cycle adds one.
- A stall that resolves on exactly the `WAIT_LIMIT`-th stall cycle still traps. The timeout check takes priority over `mem_ready` arriving late.
- Asserting `rst` mid-instruction forces FETCH immediately (asynchronously), clears the counter and both sticky flags, and deasserts `reg_write`/`mem_write` in the same cycle.

## Structure
- Package `riscv_ctrl_pkg`: `state_t` enum, opcode constants, ALUOp, `alu_control`, and `result_src`/`alu_src` encodings (e.g. `RESULT_ALUOUT`, `RESULT_DATA`, `RESULT_ALURESULT`).
- Sub-module `alu_decoder`: combinational mapping of ALUOp, `funct3`, `funct7b5` and `op[5]` to `alu_control`.
- The top level holds the state register, next-state logic, output decode, wait counter and sticky flags.

## Test plan
- Reset, then `op`=0110011, `funct3`=000, `funct7b5`=1, `mem_ready`=1 → states 0,1,6,7,0. `alu_control`=001 in EXECUTER; `reg_write`=1 only in ALUWB with `result_src`=00.
- lw with `mem_ready` held low 3 cycles in MEMREAD → MEMREAD lasts 4 cycles and the instruction takes 8 cycles total. MEMWB shows `result_src`=01.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write` pulses in BEQ only for the first; each takes 3 cycles.
- `WAIT_LIMIT`=15 and `mem_ready` never asserted from reset → TRAP at cycle 16, `bus_error`=1, `mem_req`=0, state held for 20 further cycles.
- `op`=1111111 → TRAP after DECODE with `illegal_instr`=1. `rst` pulse → FETCH and both flags 0.
- jal → states 0,1,9,7,0. JAL shows A=01, B=10, `pc_write`=1. `rst` asserted in ALUWB → `reg_write` drops without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
  localparam logic [1:0] RESULT_DATA      = 2'b01;
  localparam logic [1:0] RESULT_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Instruction class dispatch out of DECODE; unknown opcodes trap.
  function automatic state_t decode_dispatch(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LOAD,
      OP_STORE: nxt = S_MEMADR;
      OP_RTYPE: nxt = S_EXECUTER;
      OP_ITYPE: nxt = S_EXECUTEI;
      OP_JAL:   nxt = S_JAL;
      OP_BEQ:   nxt = S_BEQ;
      default:  nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Maps the main FSM's ALUOp plus instruction funct fields onto the ALU
// operation code.
import riscv_ctrl_pkg::*;

module alu_decoder (
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  alu_control
);

  // funct7b5 only selects sub for R-type; I-type addi reuses bit 30 as immediate.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (funct7b5 && op5) alu_control = ALU_SUB;
            else                 alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control: state sequencing, datapath control decode,
// memory stall timeout and sticky trap flags.
import riscv_ctrl_pkg::*;

module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic        reg_write,
  output logic [3:0]  state_o,
  output logic        bus_error,
  output logic        illegal_instr
);

  localparam int         CW         = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam bit         TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam logic [CW-1:0] WAIT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] LIMIT_M1  = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : {CW{1'b0}};

  state_t         state;
  state_t         next_state;
  aluop_t         alu_op;
  logic [CW-1:0]  wait_count;
  logic           timeout;

  assign state_o = state;

  // Timeout wins over a late mem_ready; a zero-wait access can never time out.
  always_comb begin
    timeout = 1'b0;
    if (TIMEOUT_EN && mem_req && (wait_count == LIMIT_M1) &&
        (!mem_ready || (wait_count != {CW{1'b0}}))) begin
      timeout = 1'b1;
    end else begin
      timeout = 1'b0;
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (timeout)        next_state = S_TRAP;
        else if (mem_ready) next_state = S_DECODE;
        else                next_state = S_FETCH;
      end
      S_DECODE:   next_state = decode_dispatch(op);
      S_MEMADR: begin
        if (op[5]) next_state = S_MEMWRITE;
        else       next_state = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (timeout)        next_state = S_TRAP;
        else if (mem_ready) next_state = S_MEMWB;
        else                next_state = S_MEMREAD;
      end
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: begin
        if (timeout)        next_state = S_TRAP;
        else if (mem_ready) next_state = S_FETCH;
        else                next_state = S_MEMWRITE;
      end
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_TRAP;
    endcase
  end

  // Datapath control decode; only FETCH and BEQ carry input-gated terms.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RESULT_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RESULT_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RESULT_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
      end
      S_TRAP:  mem_req = 1'b0;
      default: mem_req = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  // State register, saturating stall counter and sticky trap causes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH;
      wait_count    <= {CW{1'b0}};
      bus_error     <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_ready || (next_state != state)) begin
        wait_count <= {CW{1'b0}};
      end else if (mem_req && (wait_count != WAIT_MAX)) begin
        wait_count <= wait_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        wait_count <= wait_count;
      end
      if (timeout) begin
        bus_error <= 1'b1;
      end
      if ((state == S_DECODE) && (next_state == S_TRAP)) begin
        illegal_instr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction sequences, stalls,
// timeout, illegal opcode and asynchronous reset behaviour.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_write;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_control;
  logic        reg_write;
  logic [3:0]  state_o;
  logic        bus_error;
  logic        illegal_instr;

  int errors = 0;
  int checks = 0;

  multicycle_control_fsm #(.WAIT_LIMIT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .state_o       (state_o),
    .bus_error     (bus_error),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_src_b", 32'(alu_src_b), 32'd2);
    chk("rst_result_src", 32'(result_src), 32'd2);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_others", 32'({mem_write, adr_src, ir_write, pc_write, reg_write,
                           alu_src_a, bus_error, illegal_instr}), 32'd0);

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("r_fetch", 32'(state_o), 32'd0);
    chk("r_fetch_irw", 32'({ir_write, pc_write}), 32'd3);
    step();
    chk("r_decode", 32'(state_o), 32'd1);
    chk("r_decode_src", 32'({alu_src_a, alu_src_b}), 32'b0101);
    step();
    chk("r_exec", 32'(state_o), 32'd6);
    chk("r_exec_alu", 32'(alu_control), 32'b001);
    chk("r_exec_src", 32'({alu_src_a, alu_src_b}), 32'b1000);
    chk("r_exec_regw", 32'(reg_write), 32'd0);
    step();
    chk("r_aluwb", 32'(state_o), 32'd7);
    chk("r_aluwb_regw", 32'({reg_write, result_src}), 32'b100);
    step();
    chk("r_back_fetch", 32'(state_o), 32'd0);

    // I-type addi with bit 30 set still adds; then I-type ori
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step();
    chk("i_exec", 32'(state_o), 32'd8);
    chk("i_addi_alu", 32'(alu_control), 32'b000);
    chk("i_exec_src", 32'({alu_src_a, alu_src_b}), 32'b1001);
    step(); step();
    funct3 = 3'b110;
    step(); step();
    chk("i_ori_alu", 32'(alu_control), 32'b011);
    step(); step();
    chk("i_back_fetch", 32'(state_o), 32'd0);

    // lw with three stall cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010;
    step();
    step();
    chk("lw_memadr", 32'(state_o), 32'd2);
    mem_ready = 1'b0;
    step(); step(); step();
    chk("lw_stall3", 32'(state_o), 32'd3);
    chk("lw_memread_ctl", 32'({mem_req, adr_src, result_src}), 32'b1100);
    step();
    chk("lw_memread4", 32'(state_o), 32'd3);
    mem_ready = 1'b1;
    step();
    chk("lw_memwb", 32'(state_o), 32'd4);
    chk("lw_memwb_ctl", 32'({reg_write, result_src}), 32'b101);
    step();
    chk("lw_back_fetch", 32'(state_o), 32'd0);

    // sw with 13 stalls completes without timeout
    op = 7'b0100011;
    step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("sw_stall13", 32'(state_o), 32'd5);
    chk("sw_write_ctl", 32'({mem_req, mem_write, adr_src}), 32'b111);
    mem_ready = 1'b1;
    step();
    chk("sw_back_fetch", 32'(state_o), 32'd0);
    chk("sw_no_bus_error", 32'(bus_error), 32'd0);

    // beq taken then not taken
    op = 7'b1100011; zero = 1'b1;
    step(); step();
    chk("beq1_state", 32'(state_o), 32'd10);
    chk("beq1_pcw", 32'(pc_write), 32'd1);
    chk("beq1_alu", 32'(alu_control), 32'b001);
    step();
    chk("beq1_fetch", 32'(state_o), 32'd0);
    zero = 1'b0;
    step(); step();
    chk("beq0_state", 32'(state_o), 32'd10);
    chk("beq0_pcw", 32'(pc_write), 32'd0);
    step();
    chk("beq0_fetch", 32'(state_o), 32'd0);

    // jal, then asynchronous reset while in ALUWB
    op = 7'b1101111;
    step(); step();
    chk("jal_state", 32'(state_o), 32'd9);
    chk("jal_ctl", 32'({alu_src_a, alu_src_b, pc_write}), 32'b01101);
    step();
    chk("jal_aluwb", 32'(state_o), 32'd7);
    chk("jal_aluwb_regw", 32'(reg_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_regw", 32'(reg_write), 32'd0);
    chk("async_rst_state", 32'(state_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    // illegal opcode traps after DECODE
    op = 7'b1111111;
    step();
    chk("ill_decode", 32'(state_o), 32'd1);
    step();
    chk("ill_trap", 32'(state_o), 32'd11);
    chk("ill_flag", 32'({illegal_instr, mem_req, bus_error}), 32'b100);
    step();
    chk("ill_hold", 32'(state_o), 32'd11);
    #2 rst = 1'b1;
    #1;
    chk("ill_rst_state", 32'(state_o), 32'd0);
    chk("ill_rst_flags", 32'({illegal_instr, bus_error}), 32'd0);

    // memory never ready: timeout in FETCH
    mem_ready = 1'b0; op = 7'b0110011;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_cycle15", 32'(state_o), 32'd0);
    chk("to_cycle15_flag", 32'(bus_error), 32'd0);
    step();
    chk("to_trap", 32'(state_o), 32'd11);
    chk("to_bus_error", 32'({bus_error, mem_req, pc_write, ir_write}), 32'b1000);
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("to_hold", 32'(state_o), 32'd11);
    chk("to_hold_flags", 32'({bus_error, illegal_instr}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
